// File: rtl/cache_mem_arbiter.sv
// Memory-side port arbiter for icache refills, dcache refills/writebacks and uncached accesses.
// Independent read and write FSMs, one outstanding transaction each.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_W     = 256,
    parameter int unsigned OFF_W      = 5,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              icache_rd_req,
    input  logic [ADDR_W-1:0] icache_rd_addr,
    output logic              icache_rd_rdy,
    output logic              icache_ret_valid,
    output logic [LINE_W-1:0] icache_ret_data,
    input  logic              dcache_rd_req,
    input  logic [ADDR_W-1:0] dcache_rd_addr,
    output logic              dcache_rd_rdy,
    output logic              dcache_ret_valid,
    output logic [LINE_W-1:0] dcache_ret_data,
    input  logic              dcache_wr_req,
    input  logic [ADDR_W-1:0] dcache_wr_addr,
    input  logic [LINE_W-1:0] dcache_wr_data,
    output logic              dcache_wr_rdy,
    input  logic              duc_ren,
    input  logic [ADDR_W-1:0] duc_araddr,
    output logic              duc_rvalid,
    output logic [31:0]       duc_rdata,
    input  logic              duc_wen,
    input  logic [ADDR_W-1:0] duc_awaddr,
    input  logic [31:0]       duc_wdata,
    input  logic [3:0]        duc_strb,
    output logic              duc_bvalid,
    output logic              mem_rd_req,
    output logic [2:0]        mem_rd_type,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_rdy,
    input  logic              mem_ret_valid,
    input  logic [LINE_W-1:0] mem_ret_data,
    output logic              mem_wr_req,
    output logic [2:0]        mem_wr_type,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [3:0]        mem_wr_strb,
    output logic [LINE_W-1:0] mem_wr_data,
    input  logic              mem_wr_rdy,
    input  logic              mem_bvalid
);

    localparam int unsigned     CntW      = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);
    localparam logic [2:0]      TypeLine  = 3'b100;
    localparam logic [2:0]      TypeUc    = 3'b010;

    typedef enum logic [1:0] {RIdle, RReq, RWait} rd_state_e;
    typedef enum logic [1:0] {WIdle, WReq, WWait} wr_state_e;
    typedef enum logic [1:0] {SrcIc, SrcDc, SrcUc} rd_src_e;

    rd_state_e         rd_state_q, rd_state_d;
    rd_src_e           rd_src_q, rd_src_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [2:0]        rd_type_q, rd_type_d;
    logic [CntW-1:0]   starve_q, starve_d;

    wr_state_e         wr_state_q, wr_state_d;
    logic              wr_uc_q, wr_uc_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [2:0]        wr_type_q, wr_type_d;
    logic [3:0]        wr_strb_q, wr_strb_d;
    logic [LINE_W-1:0] wr_data_q, wr_data_d;

    logic gnt_ic, gnt_dc, gnt_uc, dc_haz, uc_haz, rd_ret;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= RIdle;
            rd_src_q   <= SrcIc;
            rd_addr_q  <= '0;
            rd_type_q  <= '0;
            starve_q   <= '0;
            wr_state_q <= WIdle;
            wr_uc_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_type_q  <= '0;
            wr_strb_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_src_q   <= rd_src_d;
            rd_addr_q  <= rd_addr_d;
            rd_type_q  <= rd_type_d;
            starve_q   <= starve_d;
            wr_state_q <= wr_state_d;
            wr_uc_q    <= wr_uc_d;
            wr_addr_q  <= wr_addr_d;
            wr_type_q  <= wr_type_d;
            wr_strb_q  <= wr_strb_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Reads to the line currently being written back must wait for the write response.
    always_comb begin
        dc_haz = (wr_state_q != WIdle) &&
                 (dcache_rd_addr[ADDR_W-1:OFF_W] == wr_addr_q[ADDR_W-1:OFF_W]);
        uc_haz = (wr_state_q != WIdle) &&
                 (duc_araddr[ADDR_W-1:OFF_W] == wr_addr_q[ADDR_W-1:OFF_W]);
        gnt_ic = 1'b0;
        gnt_dc = 1'b0;
        gnt_uc = 1'b0;
        if (rd_state_q == RIdle) begin
            if (icache_rd_req && starve_q == StarveMax) gnt_ic = 1'b1;
            else if (duc_ren && !uc_haz)                gnt_uc = 1'b1;
            else if (dcache_rd_req && !dc_haz)          gnt_dc = 1'b1;
            else if (icache_rd_req)                     gnt_ic = 1'b1;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_src_d   = rd_src_q;
        rd_addr_d  = rd_addr_q;
        rd_type_d  = rd_type_q;
        unique case (rd_state_q)
            RIdle: begin
                if (gnt_uc) begin
                    rd_state_d = RReq;
                    rd_src_d   = SrcUc;
                    rd_addr_d  = duc_araddr;
                    rd_type_d  = TypeUc;
                end else if (gnt_dc) begin
                    rd_state_d = RReq;
                    rd_src_d   = SrcDc;
                    rd_addr_d  = dcache_rd_addr;
                    rd_type_d  = TypeLine;
                end else if (gnt_ic) begin
                    rd_state_d = RReq;
                    rd_src_d   = SrcIc;
                    rd_addr_d  = icache_rd_addr;
                    rd_type_d  = TypeLine;
                end
            end
            RReq:    if (mem_rd_rdy) rd_state_d = RWait;
            RWait:   if (mem_ret_valid) rd_state_d = RIdle;
            default: rd_state_d = RIdle;
        endcase

        starve_d = starve_q;
        if (!icache_rd_req || gnt_ic) begin
            starve_d = '0;
        end else if ((gnt_dc || gnt_uc) && starve_q != StarveMax) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_uc_d    = wr_uc_q;
        wr_addr_d  = wr_addr_q;
        wr_type_d  = wr_type_q;
        wr_strb_d  = wr_strb_q;
        wr_data_d  = wr_data_q;
        unique case (wr_state_q)
            WIdle: begin
                if (dcache_wr_req) begin
                    wr_state_d = WReq;
                    wr_uc_d    = 1'b0;
                    wr_addr_d  = dcache_wr_addr;
                    wr_type_d  = TypeLine;
                    wr_strb_d  = 4'hF;
                    wr_data_d  = dcache_wr_data;
                end else if (duc_wen) begin
                    wr_state_d = WReq;
                    wr_uc_d    = 1'b1;
                    wr_addr_d  = duc_awaddr;
                    wr_type_d  = TypeUc;
                    wr_strb_d  = duc_strb;
                    wr_data_d  = LINE_W'(duc_wdata);
                end
            end
            WReq:    if (mem_wr_rdy) wr_state_d = WWait;
            WWait:   if (mem_bvalid) wr_state_d = WIdle;
            default: wr_state_d = WIdle;
        endcase
    end

    // Pulses are gated by reset so every output reads 0 while reset is held.
    always_comb begin
        rd_ret           = (rd_state_q == RWait) && mem_ret_valid && !reset;
        icache_rd_rdy    = gnt_ic && !reset;
        dcache_rd_rdy    = gnt_dc && !reset;
        icache_ret_valid = rd_ret && (rd_src_q == SrcIc);
        dcache_ret_valid = rd_ret && (rd_src_q == SrcDc);
        duc_rvalid       = rd_ret && (rd_src_q == SrcUc);
        icache_ret_data  = icache_ret_valid ? mem_ret_data : '0;
        dcache_ret_data  = dcache_ret_valid ? mem_ret_data : '0;
        duc_rdata        = duc_rvalid ? mem_ret_data[31:0] : '0;
        mem_rd_req       = (rd_state_q == RReq);
        mem_rd_type      = rd_type_q;
        mem_rd_addr      = rd_addr_q;
        dcache_wr_rdy    = (wr_state_q == WIdle) && !reset;
        duc_bvalid       = (wr_state_q == WWait) && mem_bvalid && wr_uc_q && !reset;
        mem_wr_req       = (wr_state_q == WReq);
        mem_wr_type      = wr_type_q;
        mem_wr_addr      = wr_addr_q;
        mem_wr_strb      = wr_strb_q;
        mem_wr_data      = wr_data_q;
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_cache_mem_arbiter;
    localparam int unsigned ADDR_W = 32, LINE_W = 256, OFF_W = 5, STARVE_MAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic icache_rd_req, icache_rd_rdy, icache_ret_valid;
    logic [ADDR_W-1:0] icache_rd_addr;
    logic [LINE_W-1:0] icache_ret_data;
    logic dcache_rd_req, dcache_rd_rdy, dcache_ret_valid, dcache_wr_req, dcache_wr_rdy;
    logic [ADDR_W-1:0] dcache_rd_addr, dcache_wr_addr;
    logic [LINE_W-1:0] dcache_ret_data, dcache_wr_data;
    logic duc_ren, duc_rvalid, duc_wen, duc_bvalid;
    logic [ADDR_W-1:0] duc_araddr, duc_awaddr;
    logic [31:0] duc_rdata, duc_wdata;
    logic [3:0] duc_strb;
    logic mem_rd_req, mem_rd_rdy, mem_ret_valid, mem_wr_req, mem_wr_rdy, mem_bvalid;
    logic [2:0] mem_rd_type, mem_wr_type;
    logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
    logic [LINE_W-1:0] mem_ret_data, mem_wr_data;
    logic [3:0] mem_wr_strb;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFF_W(OFF_W),
                        .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .icache_rd_req(icache_rd_req), .icache_rd_addr(icache_rd_addr),
        .icache_rd_rdy(icache_rd_rdy), .icache_ret_valid(icache_ret_valid),
        .icache_ret_data(icache_ret_data),
        .dcache_rd_req(dcache_rd_req), .dcache_rd_addr(dcache_rd_addr),
        .dcache_rd_rdy(dcache_rd_rdy), .dcache_ret_valid(dcache_ret_valid),
        .dcache_ret_data(dcache_ret_data),
        .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr),
        .dcache_wr_data(dcache_wr_data), .dcache_wr_rdy(dcache_wr_rdy),
        .duc_ren(duc_ren), .duc_araddr(duc_araddr), .duc_rvalid(duc_rvalid),
        .duc_rdata(duc_rdata), .duc_wen(duc_wen), .duc_awaddr(duc_awaddr),
        .duc_wdata(duc_wdata), .duc_strb(duc_strb), .duc_bvalid(duc_bvalid),
        .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr),
        .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid), .mem_ret_data(mem_ret_data),
        .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type), .mem_wr_addr(mem_wr_addr),
        .mem_wr_strb(mem_wr_strb), .mem_wr_data(mem_wr_data),
        .mem_wr_rdy(mem_wr_rdy), .mem_bvalid(mem_bvalid)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic any_out();
        return |{icache_rd_rdy, icache_ret_valid, icache_ret_data, dcache_rd_rdy,
                 dcache_ret_valid, dcache_ret_data, duc_rvalid, duc_rdata, duc_bvalid,
                 mem_rd_req, mem_rd_type, mem_rd_addr, mem_wr_req, mem_wr_type,
                 mem_wr_addr, mem_wr_strb, mem_wr_data};
    endfunction

    // Memory responder and requester agents configuration/state
    int rd_rdy_dly = 0, ret_dly = 1, wr_rdy_dly = 0, b_dly = 1;
    bit hold_b = 0, keep_dc = 0;
    logic [255:0] ret_line = '0;
    int r_cnt = 0, r_after = 0, w_cnt = 0, w_after = 0, mem_rets = 0;
    bit r_out = 0, w_out = 0;
    bit drop_ic = 0, drop_dc = 0, drop_uc = 0, drop_wr = 0, drop_uw = 0;

    // Monitor logs
    int gnt_q[$];
    logic [31:0] acc_addr_q[$];
    logic [2:0] acc_type_q[$];
    int ic_rets = 0, dc_rets = 0, uc_rets = 0, bvs = 0, wr_accs = 0;
    int ic_gnt_cyc = -1, dc_gnt_cyc = -1, first_req_cyc = -1, rd_req_cycles = 0, b_cyc = -1;
    logic [255:0] ic_data, wr_data_l;
    logic [31:0] uc_rdata, wr_addr_l;
    logic [2:0] wr_type_l;
    logic [3:0] wr_strb_l;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_rd_rdy = 0; mem_ret_valid = 0; mem_wr_rdy = 0; mem_bvalid = 0;
            if (mem_rd_req) begin
                if (r_cnt >= rd_rdy_dly) begin
                    mem_rd_rdy = 1; r_cnt = 0; r_out = 1; r_after = 0;
                end else r_cnt++;
            end else if (r_out) begin
                r_after++;
                if (r_after >= ret_dly) begin
                    mem_ret_valid = 1; mem_ret_data = ret_line; r_out = 0; mem_rets++;
                end
            end
            if (mem_wr_req) begin
                if (w_cnt >= wr_rdy_dly) begin
                    mem_wr_rdy = 1; w_cnt = 0; w_out = 1; w_after = 0;
                end else w_cnt++;
            end else if (w_out && !hold_b) begin
                w_after++;
                if (w_after >= b_dly) begin mem_bvalid = 1; w_out = 0; end
            end
            if (drop_ic) begin icache_rd_req = 0; drop_ic = 0; end
            if (drop_dc) begin if (!keep_dc) dcache_rd_req = 0; drop_dc = 0; end
            if (drop_uc) begin duc_ren = 0; drop_uc = 0; end
            if (drop_wr) begin dcache_wr_req = 0; drop_wr = 0; end
            if (drop_uw) begin duc_wen = 0; drop_uw = 0; end
        end
    end

    // Transaction-level reference model and per-cycle compare
    bit m_rd_act = 0, m_rd_acc = 0, m_wr_act = 0, m_wr_acc = 0, m_wr_uc = 0;
    int m_rd_src = 0, m_starve = 0;
    logic [31:0] m_rd_addr, m_wr_addr;
    logic [2:0] m_rd_type, m_wr_type;
    logic [3:0] m_wr_strb;
    logic [255:0] m_wr_data;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("reset_pulses", 256'({icache_rd_rdy, dcache_rd_rdy, icache_ret_valid,
                    dcache_ret_valid, duc_rvalid, duc_bvalid, dcache_wr_rdy}), 256'(0));
                m_rd_act = 0; m_rd_acc = 0; m_wr_act = 0; m_wr_acc = 0; m_starve = 0;
            end else begin
                bit e_gic, e_gdc, e_guc, uc_blk, dc_blk, e_ret;
                e_gic = 0; e_gdc = 0; e_guc = 0;
                uc_blk = m_wr_act && (duc_araddr >> OFF_W) == (m_wr_addr >> OFF_W);
                dc_blk = m_wr_act && (dcache_rd_addr >> OFF_W) == (m_wr_addr >> OFF_W);
                if (!m_rd_act) begin
                    if (icache_rd_req && m_starve >= int'(STARVE_MAX)) e_gic = 1;
                    else if (duc_ren && !uc_blk) e_guc = 1;
                    else if (dcache_rd_req && !dc_blk) e_gdc = 1;
                    else if (icache_rd_req) e_gic = 1;
                end
                chk("grant", 256'({icache_rd_rdy, dcache_rd_rdy}), 256'({e_gic, e_gdc}));
                chk("mem_rd_req", 256'(mem_rd_req), 256'(m_rd_act && !m_rd_acc));
                if (m_rd_act && !m_rd_acc) begin
                    chk("mem_rd_addr", 256'(mem_rd_addr), 256'(m_rd_addr));
                    chk("mem_rd_type", 256'(mem_rd_type), 256'(m_rd_type));
                end
                e_ret = m_rd_act && m_rd_acc && mem_ret_valid;
                chk("ret_valid", 256'({icache_ret_valid, dcache_ret_valid, duc_rvalid}),
                    256'({e_ret && m_rd_src == 0, e_ret && m_rd_src == 1, e_ret && m_rd_src == 2}));
                if (icache_ret_valid) chk("ic_data", icache_ret_data, mem_ret_data);
                if (dcache_ret_valid) chk("dc_data", dcache_ret_data, mem_ret_data);
                if (duc_rvalid) chk("uc_rdata", 256'(duc_rdata), 256'(mem_ret_data[31:0]));
                chk("wr_rdy", 256'(dcache_wr_rdy), 256'(!m_wr_act));
                chk("mem_wr_req", 256'(mem_wr_req), 256'(m_wr_act && !m_wr_acc));
                if (m_wr_act && !m_wr_acc) begin
                    chk("mem_wr_fields", {mem_wr_addr, mem_wr_type, mem_wr_strb},
                        {m_wr_addr, m_wr_type, m_wr_strb});
                    chk("mem_wr_data", mem_wr_data, m_wr_data);
                end
                chk("duc_bvalid", 256'(duc_bvalid),
                    256'(m_wr_act && m_wr_acc && mem_bvalid && m_wr_uc));

                // logging for directed checks
                if (icache_rd_rdy) begin gnt_q.push_back(0); ic_gnt_cyc = cyc; end
                if (dcache_rd_rdy) begin gnt_q.push_back(1); dc_gnt_cyc = cyc; end
                if (mem_rd_req) begin
                    rd_req_cycles++;
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                end
                if (mem_rd_req && mem_rd_rdy) begin
                    acc_addr_q.push_back(mem_rd_addr); acc_type_q.push_back(mem_rd_type);
                end
                if (icache_ret_valid) begin ic_rets++; ic_data = icache_ret_data; drop_ic = 1; end
                if (dcache_ret_valid) begin dc_rets++; drop_dc = 1; end
                if (duc_rvalid) begin uc_rets++; uc_rdata = duc_rdata; drop_uc = 1; end
                if (dcache_wr_req && dcache_wr_rdy) drop_wr = 1;
                if (mem_wr_req && mem_wr_rdy) begin
                    wr_accs++; wr_addr_l = mem_wr_addr; wr_type_l = mem_wr_type;
                    wr_strb_l = mem_wr_strb; wr_data_l = mem_wr_data;
                end
                if (duc_bvalid) begin bvs++; drop_uw = 1; end
                if (mem_bvalid) b_cyc = cyc;

                // model next state
                if (!m_rd_act) begin
                    if (e_gic || e_gdc || e_guc) begin
                        m_rd_act = 1; m_rd_acc = 0;
                        m_rd_src = e_gic ? 0 : (e_gdc ? 1 : 2);
                        m_rd_addr = e_gic ? icache_rd_addr : (e_gdc ? dcache_rd_addr : duc_araddr);
                        m_rd_type = e_guc ? 3'b010 : 3'b100;
                    end
                end else if (!m_rd_acc) begin
                    if (mem_rd_rdy) m_rd_acc = 1;
                end else if (mem_ret_valid) m_rd_act = 0;
                if (!icache_rd_req || e_gic) m_starve = 0;
                else if ((e_gdc || e_guc) && m_starve < int'(STARVE_MAX)) m_starve++;
                if (!m_wr_act) begin
                    if (dcache_wr_req) begin
                        m_wr_act = 1; m_wr_acc = 0; m_wr_uc = 0; m_wr_addr = dcache_wr_addr;
                        m_wr_type = 3'b100; m_wr_strb = 4'hF; m_wr_data = dcache_wr_data;
                    end else if (duc_wen) begin
                        m_wr_act = 1; m_wr_acc = 0; m_wr_uc = 1; m_wr_addr = duc_awaddr;
                        m_wr_type = 3'b010; m_wr_strb = duc_strb; m_wr_data = 256'(duc_wdata);
                    end
                end else if (!m_wr_acc) begin
                    if (mem_wr_rdy) m_wr_acc = 1;
                end else if (mem_bvalid) m_wr_act = 0;
            end
        end
    end

    function automatic int counter(input int which);
        case (which)
            0: return ic_rets;
            1: return dc_rets;
            2: return uc_rets;
            3: return bvs;
            4: return acc_addr_q.size();
            5: return mem_rets;
            default: return wr_accs;
        endcase
    endfunction

    task automatic wait_count(input string name, input int which, input int target, input int budget);
        int n = 0;
        while (counter(which) < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (counter(which) < target) begin
            errors++;
            $display("FAIL timeout_%s act=%0d exp=%0d", name, counter(which), target);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_logs();
        gnt_q.delete(); acc_addr_q.delete(); acc_type_q.delete();
        first_req_cyc = -1; rd_req_cycles = 0; ic_gnt_cyc = -1; dc_gnt_cyc = -1;
    endtask

    initial begin
        int s, base;
        reset = 1;
        {icache_rd_req, dcache_rd_req, dcache_wr_req, duc_ren, duc_wen} = '0;
        {icache_rd_addr, dcache_rd_addr, dcache_wr_addr, duc_araddr, duc_awaddr} = '0;
        dcache_wr_data = '0; duc_wdata = '0; duc_strb = '0;
        {mem_rd_rdy, mem_ret_valid, mem_wr_rdy, mem_bvalid} = '0;
        mem_ret_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_all_zero", 256'(any_out()), 256'(0));
        chk("reset_wr_rdy", 256'(dcache_wr_rdy), 256'(0));
        @(posedge clk); #1; reset = 0;
        idle(1);
        chk("idle_outs_zero", 256'(any_out()), 256'(0));
        chk("idle_wr_rdy", 256'(dcache_wr_rdy), 256'(1));

        // 1: single icache refill
        clear_logs(); rd_rdy_dly = 2; ret_dly = 5; ret_line = {8{32'hCAFE0001}};
        icache_rd_req = 1; icache_rd_addr = 32'h1C000040; s = cyc;
        wait_count("ic_ret", 0, 1, 40);
        idle(4);
        chk("t1_rets", 256'(ic_rets), 256'(1));
        chk("t1_one_req", 256'(acc_addr_q.size()), 256'(1));
        if (acc_addr_q.size() > 0) begin
            chk("t1_addr", 256'(acc_addr_q[0]), 256'(32'h1C000040));
            chk("t1_type", 256'(acc_type_q[0]), 256'(3'b100));
        end
        chk("t1_data", ic_data, {8{32'hCAFE0001}});
        chk("t1_gnt_cyc", 256'(ic_gnt_cyc), 256'(s));
        chk("t1_latency", 256'(first_req_cyc), 256'(s + 1));
        chk("t1_req_len", 256'(rd_req_cycles), 256'(3));

        // 2: uncached beats dcache
        clear_logs(); rd_rdy_dly = 0; ret_dly = 2; ret_line = {{7{32'h11111111}}, 32'h12345678};
        duc_ren = 1; duc_araddr = 32'h40000004; dcache_rd_req = 1; dcache_rd_addr = 32'h00002000;
        wait_count("t2_dc", 1, 1, 40);
        idle(3);
        chk("t2_uc_rets", 256'(uc_rets), 256'(1));
        chk("t2_uc_rdata", 256'(uc_rdata), 256'(32'h12345678));
        if (acc_addr_q.size() == 2) begin
            chk("t2_first", {acc_addr_q[0], acc_type_q[0]}, {32'h40000004, 3'b010});
            chk("t2_second", {acc_addr_q[1], acc_type_q[1]}, {32'h00002000, 3'b100});
        end else chk("t2_nreq", 256'(acc_addr_q.size()), 256'(2));

        // 3: icache anti-starvation
        clear_logs(); ret_dly = 1; keep_dc = 1; base = ic_rets;
        dcache_rd_req = 1; dcache_rd_addr = 32'h00000100;
        icache_rd_req = 1; icache_rd_addr = 32'h00000200;
        wait_count("t3_ic", 0, base + 1, 100);
        keep_dc = 0;
        idle(15);
        if (gnt_q.size() >= 5)
            chk("t3_order", 256'({gnt_q[0], gnt_q[1], gnt_q[2], gnt_q[3], gnt_q[4]}),
                256'({32'd1, 32'd1, 32'd1, 32'd1, 32'd0}));
        else chk("t3_ngnt", 256'(gnt_q.size()), 256'(5));

        // 4: read-after-write line hazard
        clear_logs(); hold_b = 1; base = dc_rets;
        dcache_wr_req = 1; dcache_wr_addr = 32'h80001000; dcache_wr_data = {8{32'h0BADF00D}};
        idle(3);
        dcache_rd_req = 1; dcache_rd_addr = 32'h80001010;
        idle(10);
        chk("t4_blocked", 256'(rd_req_cycles), 256'(0));
        chk("t4_wr_fields", {wr_addr_l, wr_type_l, wr_strb_l}, {32'h80001000, 3'b100, 4'hF});
        chk("t4_wr_data", wr_data_l, {8{32'h0BADF00D}});
        hold_b = 0;
        wait_count("t4_dc", 1, base + 1, 40);
        chk("t4_gnt_after_b", 256'(dc_gnt_cyc), 256'(b_cyc + 1));
        chk("t4_req_after_b", 256'(first_req_cyc), 256'(b_cyc + 2));

        // 5: uncached partial write
        idle(3); b_dly = 3; base = bvs;
        duc_wen = 1; duc_awaddr = 32'h40000010; duc_wdata = 32'hDEADBEEF; duc_strb = 4'b0011;
        wait_count("t5_b", 3, base + 1, 40);
        idle(5);
        chk("t5_bvs", 256'(bvs), 256'(base + 1));
        chk("t5_wr_fields", {wr_addr_l, wr_type_l, wr_strb_l}, {32'h40000010, 3'b010, 4'b0011});
        chk("t5_wr_data", wr_data_l, 256'(32'hDEADBEEF));

        // 6: reset during R_WAIT drops the return
        clear_logs(); ret_dly = 8; base = ic_rets; s = mem_rets;
        icache_rd_req = 1; icache_rd_addr = 32'h1C000080;
        wait_count("t6_acc", 4, 1, 20);
        idle(2);
        reset = 1; icache_rd_req = 0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_zero", 256'({any_out(), dcache_wr_rdy}), 256'(0));
        @(posedge clk); #1; reset = 0;
        wait_count("t6_memret", 5, s + 1, 20);
        idle(3);
        chk("t6_no_ret", 256'(ic_rets), 256'(base));
        chk("t6_outs_zero", 256'(any_out()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
